// File: rtl/key_mode_encoder.sv
// key_mode_encoder
//   Front end for the piano. It synchronises and debounces the raw key switches
//   and the mode button. It steps the OFF/PLAY/DEMO/PAUSE mode on each debounced
//   button press. It encodes the lowest-index pressed key into a note number.
//
// Ports
//   clk          system clock, every register updates on the rising edge
//   rst          synchronous reset, active-high, clears all state
//   key_in       raw key switches, 1 = pressed, asynchronous to clk
//   mode_btn     raw mode push-button, 1 = pressed, asynchronous to clk
//   key_db       debounced key levels
//   note         0 = silence, k+1 = key k sounding
//   note_valid   1 when note is non-zero
//   note_strobe  one-cycle pulse that accompanies each newly issued non-zero note
//   func         {2'b00, mode}: 0 OFF, 1 PLAY, 2 DEMO, 3 PAUSE
module key_mode_encoder #(
    parameter int N_KEYS    = 8,
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              mode_btn,
    output logic [N_KEYS-1:0] key_db,
    output logic [3:0]        note,
    output logic              note_valid,
    output logic              note_strobe,
    output logic [3:0]        func
);

    // The mode button is debounced as one extra channel above the keys.
    localparam int              N_IN    = N_KEYS + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_DEMO  = 2'd2,
        MODE_PAUSE = 2'd3
    } mode_t;

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync_p0;
    logic [N_IN-1:0] sync_p1;
    logic [N_IN-1:0] stable;
    logic [DB_W-1:0] cnt [N_IN];

    mode_t           mode;
    logic            mode_prev;
    logic            mode_rise;
    logic            note_active;
    logic [3:0]      note_next;

    // The lowest-index pressed key wins. Scanning from the top down lets the
    // last hit, which is the lowest index, overwrite any higher one.
    function automatic logic [3:0] lowest_key(input logic [N_KEYS-1:0] keys);
        logic [3:0] idx;
        idx = 4'd0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (keys[k]) begin
                idx = 4'(k + 1);
            end
        end
        return idx;
    endfunction

    assign raw = {mode_btn, key_in};

    // Stage p0/p1: two-flop synchroniser on every raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: an input must differ from its stable level for DB_CYCLES
    // consecutive cycles before it is accepted. Any return to the stable level
    // clears the counter, so a short glitch leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    stable[i] <= sync_p1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign key_db = stable[N_KEYS-1:0];

    // Only a 0->1 edge of the debounced button advances the mode. Holding the
    // button or releasing it causes no transition.
    assign mode_rise = stable[N_KEYS] & ~mode_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_OFF;
            mode_prev <= 1'b0;
        end else begin
            mode_prev <= stable[N_KEYS];
            if (mode_rise) begin
                unique case (mode)
                    MODE_OFF:   mode <= MODE_PLAY;
                    MODE_PLAY:  mode <= MODE_DEMO;
                    MODE_DEMO:  mode <= MODE_PAUSE;
                    MODE_PAUSE: mode <= MODE_OFF;
                endcase
            end
        end
    end

    assign func = {2'b00, mode};

    // Gating uses the current mode register. A key held across OFF->PLAY
    // therefore sounds one cycle after func changes. Leaving PLAY/DEMO
    // silences the note on the following cycle.
    always_comb begin
        note_active = (mode == MODE_PLAY) || (mode == MODE_DEMO);
        note_next   = note_active ? lowest_key(key_db) : 4'd0;
    end

    // Note register: the strobe marks a new non-zero value. Going silent
    // never strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            note        <= 4'd0;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            note        <= note_next;
            note_valid  <= (note_next != 4'd0);
            note_strobe <= (note_next != 4'd0) && (note_next != note);
        end
    end

endmodule
